// File: rtl/hcu_pkg.sv
// Shared types for the hazard control unit scoreboard.
// FSM state encoding, forward-select type and latency clamp helper.
package hcu_pkg;

    typedef enum logic [1:0] {
        RUN,
        BRW,
        FLUSH
    } hcu_state_t;

    typedef logic [7:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = '0;

    // Latency 0 means a single-cycle producer; anything past the
    // regfile write stage is treated as arriving at that stage.
    function automatic fwd_sel_t clamp_lat(
        input fwd_sel_t l,
        input fwd_sel_t max_lat
    );
        if (l == '0) begin
            return fwd_sel_t'(1);
        end
        if (l > max_lat) begin
            return max_lat;
        end
        return l;
    endfunction

endpackage

// File: rtl/hcu_sb_entry.sv
// One scoreboard entry: pending flag, age and latency of the youngest
// in-flight write to a register. Ports: issue_i/lat_i in; pend/age/lat out.
module hcu_sb_entry #(
    parameter int MAX_LAT = 4,
    parameter int FW      = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          issue_i,
    input  logic [FW-1:0] lat_i,
    output logic          pend_o,
    output logic [FW:0]   age_o,
    output logic [FW-1:0] lat_o
);

    localparam logic [FW:0] AGE_MAX = (FW+1)'(MAX_LAT);

    logic          pend_q, pend_d;
    logic [FW:0]   age_q, age_d;
    logic [FW-1:0] lat_q, lat_d;

    always_comb begin
        pend_d = pend_q;
        age_d  = age_q;
        lat_d  = lat_q;
        if (issue_i) begin
            // A new write replaces whatever was in flight (WAW).
            pend_d = 1'b1;
            age_d  = (FW+1)'(1);
            lat_d  = lat_i;
        end else if (pend_q) begin
            if (age_q >= AGE_MAX) begin
                // Value has reached the regfile.
                pend_d = 1'b0;
                age_d  = '0;
            end else begin
                age_d = age_q + (FW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= 1'b0;
            age_q  <= '0;
            lat_q  <= '0;
        end else begin
            pend_q <= pend_d;
            age_q  <= age_d;
            lat_q  <= lat_d;
        end
    end

    assign pend_o = pend_q;
    assign age_o  = age_q;
    assign lat_o  = lat_q;

endmodule

// File: rtl/hcu_scoreboard.sv
// Hazard control unit: age/latency scoreboard, stall/flush FSM and
// registered forward selects. In: Decode fields, mispredict_E. Out: stalls, flushes, fwd, issue.
module hcu_scoreboard
    import hcu_pkg::*;
#(
    parameter int NREGS     = 32,
    parameter int MAX_LAT   = 4,
    parameter int BR_WAIT   = 1,
    parameter int FLUSH_CYC = 1,
    localparam int AW = $clog2(NREGS),
    localparam int FW = $clog2(MAX_LAT + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          valid_D,
    input  logic [AW-1:0] rs1_D,
    input  logic [AW-1:0] rs2_D,
    input  logic          rs1_used_D,
    input  logic          rs2_used_D,
    input  logic [AW-1:0] rd_D,
    input  logic          we_D,
    input  logic [FW-1:0] lat_D,
    input  logic          branch_D,
    input  logic          jump_D,
    input  logic          mispredict_E,
    output logic          StallF,
    output logic          StallD,
    output logic          FlushD,
    output logic          FlushE,
    output logic [FW-1:0] fwdA_E,
    output logic [FW-1:0] fwdB_E,
    output logic          issue_D
);

    localparam int CNT_MAX = (BR_WAIT > FLUSH_CYC) ? BR_WAIT : FLUSH_CYC;
    localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    if (FLUSH_CYC < 1) begin : g_bad_flush
        $error("hcu_scoreboard: FLUSH_CYC must be at least 1");
    end

    logic [NREGS-1:0]         pend_v;
    logic [NREGS-1:0][FW:0]   age_v;
    logic [NREGS-1:0][FW-1:0] lat_v;

    logic [FW-1:0] lat_cl;
    logic          wr_en;

    assign lat_cl = FW'(clamp_lat(fwd_sel_t'(lat_D), fwd_sel_t'(MAX_LAT)));
    assign wr_en  = issue_D & we_D;

    assign pend_v[0] = 1'b0;
    assign age_v[0]  = '0;
    assign lat_v[0]  = '0;

    for (genvar r = 1; r < NREGS; r++) begin : g_ent
        hcu_sb_entry #(
            .MAX_LAT(MAX_LAT),
            .FW     (FW)
        ) u_ent (
            .clk    (clk),
            .reset_n(reset_n),
            .issue_i(wr_en && (rd_D == AW'(r))),
            .lat_i  (lat_cl),
            .pend_o (pend_v[r]),
            .age_o  (age_v[r]),
            .lat_o  (lat_v[r])
        );
    end

    // Source lookups: register 0 reads an always-idle entry.
    logic [FW:0]   a_age, b_age;
    logic [FW-1:0] a_lat, b_lat;
    logic          a_pend, b_pend;
    logic          haz_a, haz_b, hazard;
    logic [FW-1:0] sel_a, sel_b;

    always_comb begin
        a_pend = pend_v[rs1_D] & rs1_used_D;
        a_age  = age_v[rs1_D];
        a_lat  = lat_v[rs1_D];
        b_pend = pend_v[rs2_D] & rs2_used_D;
        b_age  = age_v[rs2_D];
        b_lat  = lat_v[rs2_D];
        haz_a  = a_pend && (a_age < {1'b0, a_lat});
        haz_b  = b_pend && (b_age < {1'b0, b_lat});
        hazard = valid_D & (haz_a | haz_b);
        sel_a  = FW'(FWD_RF);
        sel_b  = FW'(FWD_RF);
        if (a_pend && !haz_a) begin
            sel_a = a_age[FW-1:0];
        end
        if (b_pend && !haz_b) begin
            sel_b = b_age[FW-1:0];
        end
    end

    // Control FSM
    hcu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall, flush_d, flush_e;
    logic          br_start;

    assign br_start = valid_D & (branch_D | jump_D) & (BR_WAIT > 0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        case (state_q)
            RUN: begin
                if (hazard) begin
                    stall = 1'b1;
                end else if (br_start) begin
                    // This cycle is the first wait cycle; the counter
                    // holds the wait cycles still to come.
                    stall   = 1'b1;
                    state_d = BRW;
                    cnt_d   = CW'(BR_WAIT - 1);
                end
            end
            BRW: begin
                stall = hazard || (cnt_q != '0);
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!hazard) begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                if (cnt_q <= CW'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        if (mispredict_E) begin
            stall   = 1'b0;
            flush_d = 1'b1;
            flush_e = 1'b1;
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_CYC);
        end
    end

    assign StallF  = stall;
    assign StallD  = stall;
    assign FlushD  = flush_d;
    assign FlushE  = flush_e | stall;
    assign issue_D = valid_D & ~stall & ~flush_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Forward selects follow the instruction into Execute; any bubble
    // entering Execute carries the regfile select.
    logic [FW-1:0] fwd_a_q, fwd_a_d;
    logic [FW-1:0] fwd_b_q, fwd_b_d;

    always_comb begin
        fwd_a_d = FW'(FWD_RF);
        fwd_b_d = FW'(FWD_RF);
        if (issue_D) begin
            fwd_a_d = sel_a;
            fwd_b_d = sel_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwdA_E = fwd_a_q;
    assign fwdB_E = fwd_b_q;

endmodule

// File: tb/tb_hcu_scoreboard.sv
// Self-checking bench for hcu_scoreboard: directed scenarios with literal
// expectations plus randomized traffic against a timestamp-based model.
module tb_hcu_scoreboard;

    localparam int NREGS     = 32;
    localparam int MAX_LAT   = 4;
    localparam int BR_WAIT   = 2;
    localparam int FLUSH_CYC = 2;
    localparam int AW        = 5;
    localparam int FW        = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          valid_D = 1'b0;
    logic [AW-1:0] rs1_D = '0, rs2_D = '0, rd_D = '0;
    logic          rs1_used_D = 1'b0, rs2_used_D = 1'b0;
    logic          we_D = 1'b0;
    logic [FW-1:0] lat_D = '0;
    logic          branch_D = 1'b0, jump_D = 1'b0, mispredict_E = 1'b0;
    logic          StallF, StallD, FlushD, FlushE, issue_D;
    logic [FW-1:0] fwdA_E, fwdB_E;

    always #5 clk = ~clk;

    hcu_scoreboard #(
        .NREGS    (NREGS),
        .MAX_LAT  (MAX_LAT),
        .BR_WAIT  (BR_WAIT),
        .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid_D     (valid_D),
        .rs1_D       (rs1_D),
        .rs2_D       (rs2_D),
        .rs1_used_D  (rs1_used_D),
        .rs2_used_D  (rs2_used_D),
        .rd_D        (rd_D),
        .we_D        (we_D),
        .lat_D       (lat_D),
        .branch_D    (branch_D),
        .jump_D      (jump_D),
        .mispredict_E(mispredict_E),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .fwdA_E      (fwdA_E),
        .fwdB_E      (fwdB_E),
        .issue_D     (issue_D)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each register remembers the cycle of its youngest write;
    // age is simply the number of cycles since then.
    int now = 0;
    int wcyc[NREGS];
    int wlat[NREGS];
    bit wval[NREGS];
    int flush_until = -100;
    int br_rel = -1;
    bit p_iss = 0;
    int p_sa = 0, p_sb = 0;
    bit m_issue = 0, m_flushd = 0;

    function automatic int clampl(input int l);
        if (l == 0) return 1;
        if (l > MAX_LAT) return MAX_LAT;
        return l;
    endfunction

    function automatic bit m_pend(input int r);
        int a;
        a = now - wcyc[r];
        return (r != 0) && wval[r] && (a >= 1) && (a <= MAX_LAT);
    endfunction

    function automatic bit m_haz(input int r, input bit used);
        return used && m_pend(r) && ((now - wcyc[r]) < wlat[r]);
    endfunction

    function automatic int m_sel(input int r, input bit used);
        if (used && m_pend(r) && ((now - wcyc[r]) >= wlat[r]))
            return now - wcyc[r];
        return 0;
    endfunction

    always @(negedge clk) begin
        bit haz, e_stall, e_fd, e_fe, e_iss;
        int ra, rb;
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) wval[r] = 0;
            flush_until = -100;
            br_rel = -1;
            p_iss = 0;
            m_issue = 0;
            m_flushd = 0;
        end else begin
            ra = int'(rs1_D);
            rb = int'(rs2_D);
            haz = valid_D && (m_haz(ra, rs1_used_D) || m_haz(rb, rs2_used_D));
            e_stall = 0;
            e_fd = 0;
            if (mispredict_E) begin
                e_fd = 1;
                flush_until = now + FLUSH_CYC;
                br_rel = -1;
            end else if (now <= flush_until) begin
                e_fd = 1;
            end else if (haz) begin
                e_stall = 1;
            end else if (br_rel > now) begin
                e_stall = 1;
            end else if (br_rel == now) begin
                br_rel = -1;
            end else if (valid_D && (branch_D || jump_D)) begin
                br_rel = now + BR_WAIT;
                e_stall = 1;
            end
            e_fe = e_fd || e_stall;
            e_iss = valid_D && !e_stall && !e_fd;
            chk("StallF", int'(StallF), int'(e_stall));
            chk("StallD", int'(StallD), int'(e_stall));
            chk("FlushD", int'(FlushD), int'(e_fd));
            chk("FlushE", int'(FlushE), int'(e_fe));
            chk("issue_D", int'(issue_D), int'(e_iss));
            chk("fwdA_E", int'(fwdA_E), p_iss ? p_sa : 0);
            chk("fwdB_E", int'(fwdB_E), p_iss ? p_sb : 0);
            p_iss = e_iss;
            p_sa = m_sel(ra, rs1_used_D);
            p_sb = m_sel(rb, rs2_used_D);
            if (e_iss && we_D && rd_D != '0) begin
                wcyc[int'(rd_D)] = now;
                wlat[int'(rd_D)] = clampl(int'(lat_D));
                wval[int'(rd_D)] = 1;
            end
            m_issue = e_iss;
            m_flushd = e_fd;
        end
        now++;
    end

    task automatic put(input bit v, input int rs1, input bit u1, input int rs2,
                       input bit u2, input int rd, input bit we, input int lat,
                       input bit br, input bit jp, input bit mp);
        @(posedge clk);
        #1;
        valid_D = v;
        rs1_D = AW'(rs1);
        rs1_used_D = u1;
        rs2_D = AW'(rs2);
        rs2_used_D = u2;
        rd_D = AW'(rd);
        we_D = we;
        lat_D = FW'(lat);
        branch_D = br;
        jump_D = jp;
        mispredict_E = mp;
        #2;
    endtask

    task automatic idle();
        put(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    bit c_v, c_u1, c_u2, c_we, c_br, c_jp;
    int c_rs1, c_rs2, c_rd, c_lat;

    initial begin
        #2;
        chk("rst_StallD", int'(StallD), 0);
        chk("rst_FlushE", int'(FlushE), 0);
        chk("rst_fwdA", int'(fwdA_E), 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // ALU -> dependent ALU
        put(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        chk("alu_issue", int'(issue_D), 1);
        put(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("alu_dep_stall", int'(StallD), 0);
        chk("alu_dep_issue", int'(issue_D), 1);
        idle();
        chk("alu_fwdA", int'(fwdA_E), 1);

        // Load-use: one bubble then forward from stage 2
        put(1, 0, 0, 0, 0, 6, 1, 2, 0, 0, 0);
        put(1, 0, 0, 6, 1, 0, 0, 1, 0, 0, 0);
        chk("lu_stall", int'(StallD), 1);
        chk("lu_flushE", int'(FlushE), 1);
        chk("lu_noissue", int'(issue_D), 0);
        put(1, 0, 0, 6, 1, 0, 0, 1, 0, 0, 0);
        chk("lu_release", int'(StallD), 0);
        chk("lu_issue", int'(issue_D), 1);
        idle();
        chk("lu_fwdB", int'(fwdB_E), 2);

        // Retirement after MAX_LAT
        put(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
        repeat (4) idle();
        put(1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("ret_stall", int'(StallD), 0);
        idle();
        chk("ret_fwdA", int'(fwdA_E), 0);

        // x0 is never tracked
        put(1, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        put(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("x0_stall", int'(StallD), 0);
        idle();
        chk("x0_fwdA", int'(fwdA_E), 0);

        // WAW: younger single-cycle write wins
        put(1, 0, 0, 0, 0, 8, 1, 3, 0, 0, 0);
        put(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
        put(1, 8, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("waw_stall", int'(StallD), 0);
        idle();
        chk("waw_fwdA", int'(fwdA_E), 1);

        // Branch wait of BR_WAIT cycles
        put(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("br_stallD0", int'(StallD), 1);
        chk("br_stallF0", int'(StallF), 1);
        chk("br_flushE0", int'(FlushE), 1);
        put(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("br_stallD1", int'(StallD), 1);
        put(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("br_stallD2", int'(StallD), 0);
        chk("br_issue", int'(issue_D), 1);

        // Mispredict during a jump wait
        put(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        chk("jp_stallD", int'(StallD), 1);
        put(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        chk("mp_flushD", int'(FlushD), 1);
        chk("mp_flushE", int'(FlushE), 1);
        chk("mp_stallF", int'(StallF), 0);
        chk("mp_issue", int'(issue_D), 0);
        idle();
        chk("fl1_flushD", int'(FlushD), 1);
        idle();
        chk("fl2_flushD", int'(FlushD), 1);
        chk("fl2_stallF", int'(StallF), 0);
        idle();
        chk("fl_done", int'(FlushD), 0);

        // Reset with three pending writes
        put(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0);
        put(1, 0, 0, 0, 0, 9, 1, 4, 0, 0, 0);
        put(1, 12, 1, 0, 0, 10, 1, 4, 0, 0, 0);
        put(1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("pre_rst_stall", int'(StallD), 1);
        chk("pre_rst_fwdA", int'(fwdA_E), 2);
        reset_n = 1'b0;
        #1;
        chk("rst_async_StallF", int'(StallF), 0);
        chk("rst_async_StallD", int'(StallD), 0);
        chk("rst_async_FlushD", int'(FlushD), 0);
        chk("rst_async_FlushE", int'(FlushE), 0);
        chk("rst_async_fwdA", int'(fwdA_E), 0);
        chk("rst_async_fwdB", int'(fwdB_E), 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        put(1, 9, 1, 10, 1, 0, 0, 1, 0, 0, 0);
        chk("post_rst_stall", int'(StallD), 0);
        chk("post_rst_issue", int'(issue_D), 1);
        idle();
        chk("post_rst_fwdA", int'(fwdA_E), 0);
        chk("post_rst_fwdB", int'(fwdB_E), 0);

        // Randomized traffic; a stalled instruction is held in Decode
        c_v = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!c_v || m_issue || m_flushd) begin
                c_v   = ($urandom_range(0, 99) < 80);
                c_rs1 = $urandom_range(0, 7);
                c_rs2 = $urandom_range(0, 7);
                c_u1  = $urandom_range(0, 1) == 1;
                c_u2  = $urandom_range(0, 1) == 1;
                c_rd  = $urandom_range(0, 7);
                c_we  = ($urandom_range(0, 99) < 70);
                c_lat = $urandom_range(0, 7);
                c_br  = ($urandom_range(0, 99) < 10);
                c_jp  = ($urandom_range(0, 99) < 5);
            end
            put(c_v, c_rs1, c_u1, c_rs2, c_u2, c_rd, c_we, c_lat,
                c_br, c_jp, ($urandom_range(0, 99) < 3));
        end
        idle();
        @(posedge clk);
        #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
